// File: rtl/memory_responder.sv
// memory_responder: nibble-wide memory decoder and responder.
//   CPU port  : memory_write_en / memory_addr / memory_write_data in,
//               memory_read_data out (registered, one-cycle latency).
//               Writes commit only on the rising edge of memory_write_en.
//   Map       : RAM 0x000-0x27F, display 0xE00-0xE4F (idx 0-79) and
//               0xE80-0xECF (idx 80-159), I/O 0xF00-0xF7F, rest unmapped.
//   I/O port  : io_addr / io_write_data / io_write_strobe out, io_read_data in.
//   Video port: video_req / video_addr in, video_ack / video_data out;
//               independent read-first port on the display array.
//   bus_fault : sticky unmapped-access flag, only with BUS_FAULT_TRAP_EN
//               defined; otherwise tied to 0.
//   Reset     : reset_n, asynchronous, active-low. Arrays are not reset.
module memory_responder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memory_write_en,
    input  logic [11:0] memory_addr,
    input  logic [3:0]  memory_write_data,
    output logic [3:0]  memory_read_data,
    output logic [6:0]  io_addr,
    output logic [3:0]  io_write_data,
    output logic        io_write_strobe,
    input  logic [3:0]  io_read_data,
    input  logic        video_req,
    input  logic [7:0]  video_addr,
    output logic        video_ack,
    output logic [3:0]  video_data,
    output logic        bus_fault
);

    localparam int unsigned RAM_DEPTH  = 640;
    localparam int unsigned DISP_DEPTH = 160;
    localparam int unsigned DISP_HALF  = 80;

    typedef enum logic {V_IDLE, V_ACK} vstate_e;

    logic [3:0] ram_mem  [RAM_DEPTH];
    logic [3:0] disp_mem [DISP_DEPTH];

    logic       is_ram, is_disp, is_io, commit;
    logic [9:0] ram_idx;
    logic [7:0] disp_idx;

    logic       we_prev_q, we_prev_d;
    logic [3:0] rd_q, rd_d;
    logic [6:0] io_addr_q, io_addr_d;
    logic [3:0] io_wdata_q, io_wdata_d;
    logic       io_strobe_q, io_strobe_d;
    vstate_e    vstate_q, vstate_d;
    logic       vack_q, vack_d;
    logic [3:0] vdata_q, vdata_d;

    // Address decode; the upper display bank sits at 0xE80 and maps to 80-159.
    always_comb begin
        is_ram   = memory_addr < 12'(RAM_DEPTH);
        is_disp  = (memory_addr[11:8] == 4'hE) && (memory_addr[6:0] < 7'(DISP_HALF));
        is_io    = memory_addr[11:7] == 5'b11110;
        ram_idx  = memory_addr[9:0];
        disp_idx = memory_addr[7] ? 8'(memory_addr[6:0]) + 8'(DISP_HALF)
                                  : 8'(memory_addr[6:0]);
        commit   = memory_write_en & ~we_prev_q;
    end

    // Next-state logic for the CPU read path, I/O write path and video FSM.
    always_comb begin
        we_prev_d   = memory_write_en;
        rd_d        = 4'h0;
        io_strobe_d = 1'b0;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        vstate_d    = vstate_q;
        vack_d      = 1'b0;
        vdata_d     = vdata_q;

        // CPU read is write-first: a commit to the same address returns new data.
        if (is_ram) begin
            rd_d = commit ? memory_write_data : ram_mem[ram_idx];
        end else if (is_disp) begin
            rd_d = commit ? memory_write_data : disp_mem[disp_idx];
        end else if (is_io) begin
            rd_d = io_read_data;
        end

        if (commit && is_io) begin
            io_strobe_d = 1'b1;
            io_addr_d   = memory_addr[6:0];
            io_wdata_d  = memory_write_data;
        end

        // Video read sees the array before any same-edge CPU write (read-first).
        case (vstate_q)
            V_IDLE: begin
                if (video_req) begin
                    vstate_d = V_ACK;
                    vack_d   = 1'b1;
                    vdata_d  = (video_addr < 8'(DISP_DEPTH)) ? disp_mem[video_addr] : 4'h0;
                end
            end
            V_ACK: begin
                vstate_d = V_IDLE;
            end
            default: begin
                vstate_d = V_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_prev_q   <= 1'b0;
            rd_q        <= 4'h0;
            io_strobe_q <= 1'b0;
            io_addr_q   <= 7'h0;
            io_wdata_q  <= 4'h0;
            vstate_q    <= V_IDLE;
            vack_q      <= 1'b0;
            vdata_q     <= 4'h0;
        end else begin
            we_prev_q   <= we_prev_d;
            rd_q        <= rd_d;
            io_strobe_q <= io_strobe_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
            vstate_q    <= vstate_d;
            vack_q      <= vack_d;
            vdata_q     <= vdata_d;
        end
    end

    // Storage arrays keep their contents through reset.
    always_ff @(posedge clk) begin
        if (commit && is_ram) begin
            ram_mem[ram_idx] <= memory_write_data;
        end
        if (commit && is_disp) begin
            disp_mem[disp_idx] <= memory_write_data;
        end
    end

`ifdef BUS_FAULT_TRAP_EN
    logic bus_fault_q, bus_fault_d;

    // memory_addr is read on every edge, so any unmapped address trips the flag.
    always_comb begin
        bus_fault_d = bus_fault_q | ~(is_ram | is_disp | is_io);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_fault_q <= 1'b0;
        end else begin
            bus_fault_q <= bus_fault_d;
        end
    end

    assign bus_fault = bus_fault_q;
`else
    assign bus_fault = 1'b0;
`endif

    assign memory_read_data = rd_q;
    assign io_addr          = io_addr_q;
    assign io_write_data    = io_wdata_q;
    assign io_write_strobe  = io_strobe_q;
    assign video_ack        = vack_q;
    assign video_data       = vdata_q;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: a per-cycle stimulus task updates a
// behavioural memory map model and queues expected read data, I/O strobes and
// video acks; an independent monitor pops and compares on every clock edge.
module tb_memory_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        memory_write_en;
    logic [11:0] memory_addr;
    logic [3:0]  memory_write_data;
    logic [3:0]  memory_read_data;
    logic [6:0]  io_addr;
    logic [3:0]  io_write_data;
    logic        io_write_strobe;
    logic [3:0]  io_read_data;
    logic        video_req;
    logic [7:0]  video_addr;
    logic        video_ack;
    logic [3:0]  video_data;
    logic        bus_fault;

    memory_responder dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .memory_write_en   (memory_write_en),
        .memory_addr       (memory_addr),
        .memory_write_data (memory_write_data),
        .memory_read_data  (memory_read_data),
        .io_addr           (io_addr),
        .io_write_data     (io_write_data),
        .io_write_strobe   (io_write_strobe),
        .io_read_data      (io_read_data),
        .video_req         (video_req),
        .video_addr        (video_addr),
        .video_ack         (video_ack),
        .video_data        (video_data),
        .bus_fault         (bus_fault)
    );

    initial forever #5 clk = ~clk;

    localparam int K_RAM  = 0;
    localparam int K_DISP = 1;
    localparam int K_IO   = 2;
    localparam int K_UNM  = 3;

    typedef struct { logic [3:0] d; logic f; } rd_t;
    typedef struct { int c; logic [3:0] d; } vid_t;
    typedef struct { int c; logic [6:0] a; logic [3:0] d; } io_t;

    rd_t  rd_q  [$];
    vid_t vid_q [$];
    io_t  io_q  [$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit run    = 1'b0;

    logic [3:0] ram_m  [640];
    logic [3:0] disp_m [160];
    bit m_prev  = 1'b0;
    bit m_busy  = 1'b0;
    bit m_fault = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory map from plain address ranges.
    function automatic void decode(input int a, output int kind, output int idx);
        if (a < 640) begin
            kind = K_RAM;  idx = a;
        end else if (a >= 'hE00 && a < 'hE50) begin
            kind = K_DISP; idx = a - 'hE00;
        end else if (a >= 'hE80 && a < 'hED0) begin
            kind = K_DISP; idx = a - 'hE80 + 80;
        end else if (a >= 'hF00 && a < 'hF80) begin
            kind = K_IO;   idx = a - 'hF00;
        end else begin
            kind = K_UNM;  idx = 0;
        end
    endfunction

    // Drive one cycle of stimulus and queue what the next rising edge must produce.
    task automatic step(input logic we, input logic [11:0] a, input logic [3:0] wd,
                        input logic vr, input logic [7:0] va);
        int         kind, idx, e;
        logic [3:0] rd_e, io_v, vd;
        bit         commit, acc;
        @(negedge clk);
        io_v              = 4'($urandom);
        memory_write_en   = we;
        memory_addr       = a;
        memory_write_data = wd;
        video_req         = vr;
        video_addr        = va;
        io_read_data      = io_v;
        e   = cyc + 1;
        run = 1'b1;
        if (!reset_n) begin
            m_prev  = 1'b0;
            m_busy  = 1'b0;
            m_fault = 1'b0;
            rd_q.push_back('{d: 4'h0, f: 1'b0});
        end else begin
            commit = we && !m_prev;
            m_prev = we;
            decode(int'(a), kind, idx);
            // Port can take a new request only when it is not presenting an ack.
            acc = vr && !m_busy;
            if (acc) begin
                vd = (va < 160) ? disp_m[va] : 4'h0;
                vid_q.push_back('{c: e, d: vd});
            end
            m_busy = acc;
            rd_e = 4'h0;
            case (kind)
                K_RAM:   rd_e = commit ? wd : ram_m[idx];
                K_DISP:  rd_e = commit ? wd : disp_m[idx];
                K_IO:    rd_e = io_v;
                default: rd_e = 4'h0;
            endcase
            if (commit) begin
                case (kind)
                    K_RAM:   ram_m[idx] = wd;
                    K_DISP:  disp_m[idx] = wd;
                    K_IO:    io_q.push_back('{c: e, a: 7'(idx), d: wd});
                    default: ;
                endcase
            end
`ifdef BUS_FAULT_TRAP_EN
            if (kind == K_UNM) m_fault = 1'b1;
`endif
            rd_q.push_back('{d: rd_e, f: m_fault});
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard after every edge.
    initial begin : monitor
        rd_t  r;
        vid_t v;
        io_t  w;
        bit   exp_ack, exp_stb;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (run) begin
                if (rd_q.size() == 0) begin
                    chk("rd_q_underflow", rd_q.size(), 1);
                end else begin
                    r = rd_q.pop_front();
                    chk("read_data", memory_read_data, r.d);
                    chk("bus_fault", bus_fault, r.f);
                end
                exp_ack = (vid_q.size() > 0) && (vid_q[0].c == cyc);
                chk("video_ack", video_ack, exp_ack);
                if (exp_ack) begin
                    v = vid_q.pop_front();
                    chk("video_data", video_data, v.d);
                end
                exp_stb = (io_q.size() > 0) && (io_q[0].c == cyc);
                chk("io_strobe", io_write_strobe, exp_stb);
                if (exp_stb) begin
                    w = io_q.pop_front();
                    chk("io_addr", io_addr, w.a);
                    chk("io_wdata", io_write_data, w.d);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [11:0] a, prev_a;
        logic [7:0]  pva;
        bit          pend;
        logic        exp_flt;

        reset_n           = 1'b0;
        memory_write_en   = 1'b0;
        memory_addr       = 12'h0;
        memory_write_data = 4'h0;
        io_read_data      = 4'h0;
        video_req         = 1'b0;
        video_addr        = 8'h0;

        // Reset values.
        #12;
        chk("rst_read_data", memory_read_data, 4'h0);
        chk("rst_io_strobe", io_write_strobe, 1'b0);
        chk("rst_io_addr",   io_addr, 7'h0);
        chk("rst_io_wdata",  io_write_data, 4'h0);
        chk("rst_video_ack", video_ack, 1'b0);
        chk("rst_video_data", video_data, 4'h0);
        chk("rst_bus_fault", bus_fault, 1'b0);

        step(1'b0, 12'h000, 4'h0, 1'b0, 8'h0);
        step(1'b0, 12'h000, 4'h0, 1'b0, 8'h0);
        @(posedge clk); #2;
        reset_n = 1'b1;

        // Give every RAM and display location a known value.
        for (int i = 0; i < 640; i++) begin
            step(1'b1, 12'(i), 4'($urandom), 1'b0, 8'h0);
            step(1'b0, 12'(i), 4'h0, 1'b0, 8'h0);
        end
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 12'('hE00 + i), 4'($urandom), 1'b0, 8'h0);
            step(1'b0, 12'('hE00 + i), 4'h0, 1'b0, 8'h0);
            step(1'b1, 12'('hE80 + i), 4'($urandom), 1'b0, 8'h0);
            step(1'b0, 12'('hE80 + i), 4'h0, 1'b0, 8'h0);
        end

        // RAM round trip with the write enable held for two cycles.
        step(1'b1, 12'h123, 4'hA, 1'b0, 8'h0);
        step(1'b1, 12'h123, 4'h5, 1'b0, 8'h0);
        step(1'b0, 12'h123, 4'h0, 1'b0, 8'h0);
        @(posedge clk); #2;
        chk("ram_round_trip", memory_read_data, 4'hA);

        // Held write enable at an I/O address gives a single strobe.
        step(1'b1, 12'hF05, 4'h3, 1'b0, 8'h0);
        step(1'b1, 12'hF05, 4'h7, 1'b0, 8'h0);
        step(1'b1, 12'hF05, 4'h9, 1'b0, 8'h0);
        step(1'b0, 12'h000, 4'h0, 1'b0, 8'h0);
        @(posedge clk); #2;
        chk("io_held_addr",  io_addr, 7'h05);
        chk("io_held_wdata", io_write_data, 4'h3);

        // CPU write into upper display bank, then read it through the video port.
        step(1'b1, 12'hE81, 4'h6, 1'b0, 8'h0);
        step(1'b0, 12'hE81, 4'h0, 1'b1, 8'd81);
        @(posedge clk); #2;
        chk("disp_video_ack",  video_ack, 1'b1);
        chk("disp_video_data", video_data, 4'h6);
        step(1'b0, 12'hE50, 4'h0, 1'b0, 8'h0);
        @(posedge clk); #2;
        chk("disp_gap_read", memory_read_data, 4'h0);

        // Back-to-back video requests and an out-of-range index.
        step(1'b0, 12'h001, 4'h0, 1'b1, 8'd0);
        step(1'b0, 12'h001, 4'h0, 1'b1, 8'd1);
        step(1'b0, 12'h001, 4'h0, 1'b1, 8'd1);
        step(1'b0, 12'h001, 4'h0, 1'b0, 8'd0);
        step(1'b0, 12'h001, 4'h0, 1'b1, 8'd200);
        @(posedge clk); #2;
        chk("video_oor_data", video_data, 4'h0);
        step(1'b0, 12'h001, 4'h0, 1'b0, 8'd0);

        // Same-edge CPU write and video read of one display index.
        step(1'b0, 12'hE10, 4'h0, 1'b0, 8'd0);
        step(1'b1, 12'hE10, ~disp_m[16], 1'b1, 8'd16);
        step(1'b0, 12'hE10, 4'h0, 1'b0, 8'd0);

        // Unmapped read followed by valid accesses.
        step(1'b0, 12'h500, 4'h0, 1'b0, 8'h0);
        step(1'b0, 12'h123, 4'h0, 1'b0, 8'h0);
        step(1'b1, 12'h200, 4'h4, 1'b0, 8'h0);
        @(posedge clk); #2;
`ifdef BUS_FAULT_TRAP_EN
        exp_flt = 1'b1;
`else
        exp_flt = 1'b0;
`endif
        chk("fault_sticky", bus_fault, exp_flt);

        // Randomised traffic.
        pend   = 1'b0;
        pva    = 8'h0;
        prev_a = 12'h0;
        for (int i = 0; i < 3000; i++) begin
            if (m_busy) pend = 1'b0;
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                pva  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 159));
            end
            case ($urandom_range(0, 3))
                0:       a = 12'($urandom_range(0, 639));
                1:       a = ($urandom_range(0, 1) == 1) ? 12'('hE00 + $urandom_range(0, 79))
                                                         : 12'('hE80 + $urandom_range(0, 79));
                2:       a = 12'('hF00 + $urandom_range(0, 127));
                default: a = 12'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) a = prev_a;
            prev_a = a;
            step(1'($urandom_range(0, 1)), a, 4'($urandom), pend, pend ? pva : 8'($urandom));
        end

        // Asynchronous reset while an ack is being presented.
        step(1'b0, 12'h000, 4'h0, 1'b0, 8'h0);
        step(1'b0, 12'h000, 4'h0, 1'b0, 8'h0);
        step(1'b1, 12'h010, 4'hC, 1'b1, 8'd5);
        @(posedge clk); #2;
        chk("pre_rst_ack", video_ack, 1'b1);
        chk("pre_rst_rd",  memory_read_data, 4'hC);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_ack", video_ack, 1'b0);
        chk("async_rst_rd",  memory_read_data, 4'h0);

        // Write enable held high across reset release commits on the first edge.
        step(1'b1, 12'h020, 4'h5, 1'b0, 8'h0);
        step(1'b1, 12'h020, 4'h5, 1'b0, 8'h0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        step(1'b1, 12'h020, 4'h5, 1'b0, 8'h0);
        step(1'b0, 12'h020, 4'h0, 1'b0, 8'h0);
        @(posedge clk); #2;
        chk("release_commit", memory_read_data, 4'h5);

        repeat (4) step(1'b0, 12'h000, 4'h0, 1'b0, 8'h0);
        @(posedge clk); #2;
        run = 1'b0;
        chk("rd_q_left",  rd_q.size(), 0);
        chk("vid_q_left", vid_q.size(), 0);
        chk("io_q_left",  io_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
